// File: rtl/setup_sweep_ctrl.sv
// Setup-time sweep sequencer for the DYNDFF cell: drives dut_clk/dut_d and reports the smallest passing data offset.
// Optional build macro SETUP_SWEEP_REPEAT_EN runs NREP capture/clear pairs per offset.
module setup_sweep_ctrl #(
    parameter int PERIOD = 64,
    parameter int OFF_W  = 6,
    parameter int NREP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OFF_W-1:0] cfg_offset_max,
    input  logic [OFF_W-1:0] cfg_step,
    output logic             dut_clk,
    output logic             dut_d,
    input  logic             dut_q,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [OFF_W-1:0] res_offset,
    output logic [1:0]       res_status
);

    localparam int HALF  = PERIOD / 2;
    localparam int PH_W  = $clog2(PERIOD);
    localparam int CW    = ((PH_W > OFF_W) ? PH_W : OFF_W) + 1;
    localparam int REP_W = (NREP > 1) ? $clog2(NREP) : 1;
`ifdef SETUP_SWEEP_REPEAT_EN
    localparam int REPS = NREP;
`else
    localparam int REPS = 1;
`endif

    typedef enum logic [2:0] {IDLE, INIT_CLR, CAPTURE, CLEAR, DONE} state_t;
    typedef enum logic [1:0] {
        ST_OK           = 2'b00,
        ST_FAIL_MAX     = 2'b01,
        ST_NEVER_FAILED = 2'b10,
        ST_CLEAR_ERR    = 2'b11
    } status_t;

    state_t             state, state_nxt;
    logic [PH_W-1:0]    phase, phase_nxt;
    logic [OFF_W-1:0]   off, off_nxt, stp, last_pass, fin_offset;
    logic [REP_W-1:0]   rep;
    logic               q_meta, q_s, pass, first_off;
    logic               last_phase, running, clk_nxt, d_nxt;
    logic               accept, cap_end, next_rep, next_off, fin;
    status_t            fin_status;

    assign last_phase = (phase == PH_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        off_nxt    = off;
        accept     = 1'b0;
        cap_end    = 1'b0;
        next_rep   = 1'b0;
        next_off   = 1'b0;
        fin        = 1'b0;
        fin_status = ST_OK;
        fin_offset = off;
        case (state)
            IDLE: if (start && !res_valid) begin
                accept    = 1'b1;
                off_nxt   = cfg_offset_max;
                state_nxt = INIT_CLR;
            end
            INIT_CLR: if (last_phase) begin
                if (q_s) begin
                    fin        = 1'b1;
                    fin_status = ST_CLEAR_ERR;
                    state_nxt  = DONE;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: if (last_phase) begin
                cap_end   = 1'b1;
                state_nxt = CLEAR;
            end
            CLEAR: if (last_phase) begin
                fin       = 1'b1;
                state_nxt = DONE;
                if (q_s) begin
                    fin_status = ST_CLEAR_ERR;
                end else if (!pass && first_off) begin
                    fin_status = ST_FAIL_MAX;
                end else if (!pass) begin
                    fin_status = ST_OK;
                    fin_offset = last_pass;
                end else if (rep != REP_W'(REPS - 1)) begin
                    fin       = 1'b0;
                    next_rep  = 1'b1;
                    state_nxt = CAPTURE;
                end else if (off < stp) begin
                    // Stepping further would wrap below zero, so the whole range passed.
                    fin_status = ST_NEVER_FAILED;
                end else begin
                    fin       = 1'b0;
                    next_off  = 1'b1;
                    off_nxt   = off - stp;
                    state_nxt = CAPTURE;
                end
            end
            DONE: if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        running   = (state_nxt == INIT_CLR) || (state_nxt == CAPTURE) || (state_nxt == CLEAR);
        phase_nxt = (running && state_nxt == state && !last_phase) ? phase + PH_W'(1) : '0;
        // Pad outputs are registered from next-state values so they stay glitch-free and phase-aligned.
        clk_nxt   = running && (phase_nxt >= PH_W'(HALF));
        d_nxt     = (state_nxt == CAPTURE) && ((CW'(phase_nxt) + CW'(off_nxt)) >= CW'(HALF));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_meta     <= 1'b0;
            q_s        <= 1'b0;
            phase      <= '0;
            off        <= '0;
            stp        <= '0;
            last_pass  <= '0;
            rep        <= '0;
            pass       <= 1'b0;
            first_off  <= 1'b0;
            dut_clk    <= 1'b0;
            dut_d      <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_offset <= '0;
            res_status <= 2'b00;
        end else begin
            q_meta  <= dut_q;
            q_s     <= q_meta;
            phase   <= phase_nxt;
            off     <= off_nxt;
            dut_clk <= clk_nxt;
            dut_d   <= d_nxt;
            if (accept) begin
                stp       <= (cfg_step == '0) ? OFF_W'(1) : cfg_step;
                busy      <= 1'b1;
                first_off <= 1'b1;
                rep       <= '0;
                last_pass <= '0;
            end
            if (cap_end)  pass <= q_s;
            if (next_rep) rep <= rep + REP_W'(1);
            if (next_off) begin
                rep       <= '0;
                first_off <= 1'b0;
                last_pass <= off;
            end
            if (fin) begin
                res_offset <= fin_offset;
                res_status <= fin_status;
            end
            if (state == DONE && !res_valid) begin
                res_valid <= 1'b1;
                busy      <= 1'b0;
            end
            if (state == DONE && res_valid && res_ready) res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_setup_sweep_ctrl.sv
// Self-checking bench for setup_sweep_ctrl: behavioural DFF with programmable setup, vector table,
// hand-written corner sequences and randomized sweeps checked against a sweep reference model.
module tb_setup_sweep_ctrl;

    localparam int PERIOD = 64;
    localparam int OFF_W  = 6;
    localparam int CLK_NS = 10;
    localparam int LIMIT  = 40000;
`ifdef SETUP_SWEEP_REPEAT_EN
    localparam int R = 4;
`else
    localparam int R = 1;
`endif

    logic             clk = 1'b0;
    logic             rst, start, res_ready, dut_q;
    logic [OFF_W-1:0] cfg_offset_max, cfg_step, res_offset;
    logic             dut_clk, dut_d, busy, res_valid;
    logic [1:0]       res_status;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural DYNDFF: captures 1 only if dut_d has been high for >= setup_ticks reference ticks.
    int   setup_ticks = 0;
    bit   stuck       = 1'b0;
    int   d_age       = 0;
    logic q_model     = 1'b0;

    setup_sweep_ctrl #(.PERIOD(PERIOD), .OFF_W(OFF_W), .NREP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_offset_max (cfg_offset_max),
        .cfg_step       (cfg_step),
        .dut_clk        (dut_clk),
        .dut_d          (dut_d),
        .dut_q          (dut_q),
        .busy           (busy),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_offset     (res_offset),
        .res_status     (res_status)
    );

    always #(CLK_NS / 2) clk = ~clk;

    always @(negedge clk) d_age = (dut_d === 1'b1) ? d_age + 1 : 0;
    always @(posedge dut_clk) q_model <= #3 (dut_d === 1'b1) && (d_age >= setup_ticks);
    assign dut_q = stuck ? 1'b1 : q_model;

    typedef struct {
        string name;
        int    setup;
        int    mx;
        int    st;
        int    exp_status;
        int    exp_off;
        int    npass;
        int    nfail;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int latency(input int pairs);
        return 1 + PERIOD + pairs * 2 * PERIOD;
    endfunction

    // Reference sweep: walk offsets from max downward, each passes iff offset >= setup.
    function automatic void ref_sweep(input int setup, input int mx, input int st,
                                      output int status, output int offset, output int pairs);
        int  s     = (st == 0) ? 1 : st;
        int  o     = mx;
        int  last  = 0;
        bit  first = 1'b1;
        bit  done  = 1'b0;
        pairs  = 0;
        status = 0;
        offset = 0;
        while (!done) begin
            if (o < setup) begin
                pairs += 1;
                status = first ? 1 : 0;
                offset = first ? mx : last;
                done   = 1'b1;
            end else begin
                pairs += R;
                last   = o;
                if (o < s) begin
                    status = 2;
                    offset = o;
                    done   = 1'b1;
                end else begin
                    o    -= s;
                    first = 1'b0;
                end
            end
        end
    endfunction

    // Pulses start, measures cycles from the accept edge to res_valid, checks result, then handshakes.
    task automatic run_sweep(input string name, input int setup, input int mx, input int st,
                             input int exp_status, input int exp_off, input int exp_lat);
        int cnt;
        setup_ticks = setup;
        @(posedge clk); #1;
        cfg_offset_max = OFF_W'(mx);
        cfg_step       = OFF_W'(st);
        start          = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, ".busy_on_accept"}, busy, 1);
        cnt = 0;
        while (res_valid !== 1'b1 && cnt < LIMIT) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= LIMIT) check({name, ".timeout"}, cnt, exp_lat);
        check({name, ".latency"}, cnt, exp_lat);
        check({name, ".status"}, res_status, exp_status);
        check({name, ".offset"}, res_offset, exp_off);
        check({name, ".busy_done"}, busy, 0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({name, ".valid_cleared"}, res_valid, 0);
    endtask

    initial begin
        int   status, offset, pairs, s, mx, st;
        logic stable;

        vecs[0] = '{"setup7_step1",   7, 20, 1, 0,  7, 14, 1};
        vecs[1] = '{"setup7_step2",   7, 20, 2, 0,  8,  7, 1};
        vecs[2] = '{"setup25_fail",  25, 20, 1, 1, 20,  0, 1};
        vecs[3] = '{"setup0_never",   0,  4, 2, 2,  0,  3, 0};
        vecs[4] = '{"step0_as_1",    30, 32, 0, 0, 30,  3, 1};
        vecs[5] = '{"max_half",      32, 32, 5, 0, 32,  1, 1};

        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        cfg_offset_max = '0; cfg_step = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.dut_clk", dut_clk, 0);
        check("reset.dut_d", dut_d, 0);
        check("reset.busy", busy, 0);
        check("reset.res_valid", res_valid, 0);
        check("reset.res_offset", res_offset, 0);
        check("reset.res_status", res_status, 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_sweep(vecs[i].name, vecs[i].setup, vecs[i].mx, vecs[i].st, vecs[i].exp_status,
                      vecs[i].exp_off, latency(vecs[i].npass * R + vecs[i].nfail));

        // Stuck-at-1 output: clear error after INIT_CLR, then result held while res_ready stays low.
        stuck = 1'b1;
        @(posedge clk); #1;
        cfg_offset_max = 6'd20; cfg_step = 6'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int cnt = 0;
            while (res_valid !== 1'b1 && cnt < LIMIT) begin
                @(posedge clk); #1;
                cnt++;
            end
            check("stuck.latency", cnt, latency(0));
        end
        check("stuck.status", res_status, 3);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            @(posedge clk); #1;
            if (res_valid !== 1'b1 || res_status !== 2'b11 || busy !== 1'b0 || dut_clk !== 1'b0)
                stable = 1'b0;
        end
        start = 1'b0;
        check("stuck.held_stable", stable, 1);
        check("stuck.second_start_ignored", busy, 0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("stuck.valid_cleared", res_valid, 0);
        stuck = 1'b0;

        // Reset in the middle of trial 3 aborts at once; a fresh sweep reproduces the first result.
        setup_ticks = 7;
        @(posedge clk); #1;
        cfg_offset_max = 6'd20; cfg_step = 6'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (360) @(posedge clk);
        #1;
        check("abort.busy_before", busy, 1);
        check("abort.dut_clk_before", dut_clk, 1);
        #1 rst = 1'b1;
        #1;
        check("abort.dut_clk", dut_clk, 0);
        check("abort.dut_d", dut_d, 0);
        check("abort.busy", busy, 0);
        check("abort.res_valid", res_valid, 0);
        check("abort.res_offset", res_offset, 0);
        check("abort.res_status", res_status, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_sweep("after_abort", 7, 20, 1, 0, 7, latency(14 * R + 1));

        for (int k = 0; k < 6; k++) begin
            s  = $urandom_range(34, 0);
            mx = $urandom_range(32, 0);
            st = $urandom_range(7, 0);
            ref_sweep(s, mx, st, status, offset, pairs);
            run_sweep($sformatf("rand%0d", k), s, mx, st, status, offset, latency(pairs));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
